// File: rtl/ALSU_pkg.sv
// ----------------------------------------------------------------------------
// ALSU_pkg - shared ALSU opcode, packed command type and command helpers. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ALSU_pkg;

    typedef enum logic [2:0] {
        OR        = 3'd0,
        XOR       = 3'd1,
        ADD       = 3'd2,
        MULT      = 3'd3,
        SHIFT     = 3'd4,
        ROTATE    = 3'd5,
        INVALID_6 = 3'd6,
        INVALID_7 = 3'd7
    } opcode_e;

    typedef struct packed {
        opcode_e           opcode;
        logic signed [2:0] A;
        logic signed [2:0] B;
        logic              cin;
        logic              serial_in;
        logic              direction;
        logic              red_op_A;
        logic              red_op_B;
        logic              bypass_A;
        logic              bypass_B;
    } alsu_cmd_t;

    // OR of two zero operands with no flags: drives the ALSU result to 0
    localparam alsu_cmd_t ALSU_IDLE_CMD = '{
        opcode:    OR,
        A:         3'sd0,
        B:         3'sd0,
        cin:       1'b0,
        serial_in: 1'b0,
        direction: 1'b0,
        red_op_A:  1'b0,
        red_op_B:  1'b0,
        bypass_A:  1'b0,
        bypass_B:  1'b0
    };

    function automatic logic alsu_is_invalid(input alsu_cmd_t cmd);
        return (cmd.opcode == INVALID_6) || (cmd.opcode == INVALID_7) ||
               ((cmd.opcode > XOR) && (cmd.red_op_A || cmd.red_op_B));
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_lock_arbiter.sv
// ----------------------------------------------------------------------------
// rr_lock_arbiter - round-robin one-hot grant with a sticky owner lock. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_lock_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_valid,
    input  logic [N_REQ-1:0] req_lock,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             accept
);

    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic            owner_vld_q, owner_vld_d;

    always_comb begin : grant_select
        int   idx;
        logic found;
        grant    = '0;
        grant_id = '0;
        accept   = 1'b0;
        idx      = 0;
        found    = 1'b0;
        if (rst_n) begin
            if (owner_vld_q) begin
                // A held lock blocks everyone else, even while the owner is idle
                if (req_valid[owner_q]) begin
                    grant[owner_q] = 1'b1;
                    grant_id       = owner_q;
                    accept         = 1'b1;
                end
            end else begin
                for (int k = 0; k < N_REQ; k++) begin
                    idx = int'(rr_ptr_q) + k;
                    if (idx >= N_REQ) begin
                        idx = idx - N_REQ;
                    end
                    if (!found && req_valid[idx]) begin
                        found      = 1'b1;
                        grant[idx] = 1'b1;
                        grant_id   = ID_W'(idx);
                        accept     = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin : next_state
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        if (accept) begin
            rr_ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : ID_W'(grant_id + 1'b1);
            if (req_lock[grant_id]) begin
                owner_vld_d = 1'b1;
                owner_d     = grant_id;
            end else begin
                owner_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alsu_arbiter.sv
// ----------------------------------------------------------------------------
// alsu_arbiter - shares one ALSU among N_REQ requesters, returns tagged results. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alsu_arbiter
    import ALSU_pkg::*;
#(
    parameter  int N_REQ        = 2,
    parameter  int ALSU_LATENCY = 2,
    localparam int ID_W         = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0]            req_lock,
    input  alsu_cmd_t [N_REQ-1:0]       req_cmd,
    output logic                        rsp_valid,
    output logic [ID_W-1:0]             rsp_id,
    output logic signed [5:0]           rsp_out,
    output logic                        rsp_err,
    output logic signed [2:0]           alsu_A,
    output logic signed [2:0]           alsu_B,
    output opcode_e                     alsu_opcode,
    output logic                        alsu_cin,
    output logic                        alsu_serial_in,
    output logic                        alsu_direction,
    output logic                        alsu_red_op_A,
    output logic                        alsu_red_op_B,
    output logic                        alsu_bypass_A,
    output logic                        alsu_bypass_B,
    output logic                        alsu_rst,
    input  logic signed [5:0]           alsu_out
);

    localparam int DEPTH = ALSU_LATENCY + 1;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            err;
    } tag_t;

    logic [ID_W-1:0]   grant_id;
    logic              accept;
    alsu_cmd_t         sel_cmd;
    alsu_cmd_t         cmd_d, cmd_q;
    tag_t              tag_d [DEPTH];
    tag_t              tag_q [DEPTH];
    logic              rsp_valid_d, rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_d, rsp_id_q;
    logic              rsp_err_d, rsp_err_q;
    logic signed [5:0] rsp_out_d, rsp_out_q;
    logic              alsu_rst_d, alsu_rst_q;

    rr_lock_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .grant     (req_ready),
        .grant_id  (grant_id),
        .accept    (accept)
    );

    always_comb begin
        sel_cmd  = req_cmd[grant_id];
        // Idle slots still issue a command so SHIFT/ROTATE chain onto a 0 result
        cmd_d    = accept ? sel_cmd : ALSU_IDLE_CMD;
        tag_d[0] = '{valid: accept, id: grant_id, err: accept && alsu_is_invalid(sel_cmd)};
        for (int k = 1; k < DEPTH; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        rsp_valid_d = tag_q[DEPTH-1].valid;
        rsp_id_d    = tag_q[DEPTH-1].id;
        rsp_err_d   = tag_q[DEPTH-1].err;
        rsp_out_d   = alsu_out;
        alsu_rst_d  = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= ALSU_IDLE_CMD;
            for (int k = 0; k < DEPTH; k++) begin
                tag_q[k] <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
            rsp_out_q   <= '0;
            alsu_rst_q  <= 1'b1;
        end else begin
            cmd_q       <= cmd_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            rsp_out_q   <= rsp_out_d;
            alsu_rst_q  <= alsu_rst_d;
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_id         = rsp_id_q;
    assign rsp_err        = rsp_err_q;
    assign rsp_out        = rsp_out_q;
    assign alsu_rst       = alsu_rst_q;
    assign alsu_opcode    = cmd_q.opcode;
    assign alsu_A         = cmd_q.A;
    assign alsu_B         = cmd_q.B;
    assign alsu_cin       = cmd_q.cin;
    assign alsu_serial_in = cmd_q.serial_in;
    assign alsu_direction = cmd_q.direction;
    assign alsu_red_op_A  = cmd_q.red_op_A;
    assign alsu_red_op_B  = cmd_q.red_op_B;
    assign alsu_bypass_A  = cmd_q.bypass_A;
    assign alsu_bypass_B  = cmd_q.bypass_B;

endmodule

`default_nettype wire

// File: tb/tb_alsu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alsu_arbiter - directed and random checks of alsu_arbiter with an ALSU model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alsu_arbiter;
    import ALSU_pkg::*;

    localparam int N_REQ = 2;
    localparam int LAT   = 2;
    localparam int ID_W  = $clog2(N_REQ);

    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic              err;
        logic signed [5:0] out;
    } rsp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N_REQ-1:0]      req_valid, req_ready, req_lock;
    alsu_cmd_t [N_REQ-1:0] req_cmd;
    logic                  rsp_valid, rsp_err;
    logic [ID_W-1:0]       rsp_id;
    logic signed [5:0]     rsp_out;
    logic signed [2:0]     alsu_A, alsu_B;
    opcode_e               alsu_opcode;
    logic                  alsu_cin, alsu_serial_in, alsu_direction;
    logic                  alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
    logic                  alsu_rst;
    logic signed [5:0]     alsu_out;

    always #5 clk = ~clk;

    alsu_arbiter #(.N_REQ(N_REQ), .ALSU_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock), .req_cmd(req_cmd),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_err(rsp_err),
        .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
        .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in), .alsu_direction(alsu_direction),
        .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
        .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
        .alsu_rst(alsu_rst), .alsu_out(alsu_out)
    );

    function automatic logic ref_invalid(input alsu_cmd_t c);
        int op = int'(c.opcode);
        return (op >= 6) || ((op >= 2) && (c.red_op_A || c.red_op_B));
    endfunction

    // ALSU behaviour: bypass first, then invalid -> 0, then the opcode
    function automatic logic signed [5:0] alu(input alsu_cmd_t c, input logic signed [5:0] prev);
        int a = c.A;
        int b = c.B;
        int r = 0;
        logic [5:0] p = prev;
        if (c.bypass_A)          r = a;
        else if (c.bypass_B)     r = b;
        else if (ref_invalid(c)) r = 0;
        else begin
            case (int'(c.opcode))
                0: begin
                    if (c.red_op_A)      r = int'(|c.A);
                    else if (c.red_op_B) r = int'(|c.B);
                    else                 r = a | b;
                end
                1: begin
                    if (c.red_op_A)      r = int'(^c.A);
                    else if (c.red_op_B) r = int'(^c.B);
                    else                 r = a ^ b;
                end
                2: r = a + b + int'(c.cin);
                3: r = a * b;
                4: r = c.direction ? int'({p[4:0], c.serial_in}) : int'({c.serial_in, p[5:1]});
                5: r = c.direction ? int'({p[4:0], p[5]}) : int'({p[0], p[5:1]});
                default: r = 0;
            endcase
        end
        return 6'(r);
    endfunction

    // ALSU stand-in: registered inputs, registered output, async active-high reset
    alsu_cmd_t         pin_cmd, alsu_in_r;
    logic signed [5:0] alsu_out_r;
    always_comb begin
        pin_cmd           = '0;
        pin_cmd.opcode    = alsu_opcode;
        pin_cmd.A         = alsu_A;
        pin_cmd.B         = alsu_B;
        pin_cmd.cin       = alsu_cin;
        pin_cmd.serial_in = alsu_serial_in;
        pin_cmd.direction = alsu_direction;
        pin_cmd.red_op_A  = alsu_red_op_A;
        pin_cmd.red_op_B  = alsu_red_op_B;
        pin_cmd.bypass_A  = alsu_bypass_A;
        pin_cmd.bypass_B  = alsu_bypass_B;
    end
    always @(posedge clk or posedge alsu_rst) begin
        if (alsu_rst) begin
            alsu_in_r  <= '0;
            alsu_out_r <= '0;
        end else begin
            alsu_in_r  <= pin_cmd;
            alsu_out_r <= alu(alsu_in_r, alsu_out_r);
        end
    end
    assign alsu_out = alsu_out_r;

    int                n_pass = 0;
    int                n_total = 0;
    rsp_t              exp_q[$];
    int                m_ptr, m_owner;
    logic signed [5:0] m_last;
    rsp_t              obs_rsp;
    logic [N_REQ-1:0]  last_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic alsu_cmd_t mk(input opcode_e op, input int a, input int b);
        alsu_cmd_t c = '0;
        c.opcode = op;
        c.A      = 3'(a);
        c.B      = 3'(b);
        return c;
    endfunction

    function automatic rsp_t mkrsp(input logic v, input int id, input logic err, input int o);
        rsp_t r;
        r.valid = v;
        r.id    = ID_W'(id);
        r.err   = err;
        r.out   = 6'(o);
        return r;
    endfunction

    function automatic alsu_cmd_t rnd_cmd();
        alsu_cmd_t c;
        c.opcode    = opcode_e'(3'($urandom_range(0, 7)));
        c.A         = 3'($urandom);
        c.B         = 3'($urandom);
        c.cin       = 1'($urandom);
        c.serial_in = 1'($urandom);
        c.direction = 1'($urandom);
        c.red_op_A  = ($urandom_range(0, 7) == 0);
        c.red_op_B  = ($urandom_range(0, 7) == 0);
        c.bypass_A  = ($urandom_range(0, 7) == 0);
        c.bypass_B  = ($urandom_range(0, 7) == 0);
        return c;
    endfunction

    task automatic set_req(input int i, input logic v, input logic l, input alsu_cmd_t c);
        req_valid[i] = v;
        req_lock[i]  = l;
        req_cmd[i]   = c;
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_owner = -1;
        m_last  = '0;
        exp_q.delete();
        repeat (LAT + 1) exp_q.push_back('0);
    endtask

    // One clock: predict the grant, check ready, advance, check the response slot
    task automatic cycle(input string tag, output int g);
        alsu_cmd_t        c;
        rsp_t             e;
        logic [N_REQ-1:0] exp_ready;
        int               idx;
        #1;
        g = -1;
        if (m_owner >= 0) begin
            if (req_valid[m_owner]) g = m_owner;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = (m_ptr + k) % N_REQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        last_ready = req_ready;
        chk({tag, " ready"}, 32'(req_ready), 32'(exp_ready));
        if (g >= 0) begin
            c       = req_cmd[g];
            m_ptr   = (g + 1) % N_REQ;
            if (req_lock[g])       m_owner = g;
            else if (m_owner == g) m_owner = -1;
            e.valid = 1'b1;
            e.id    = ID_W'(g);
            e.err   = ref_invalid(c);
        end else begin
            c       = mk(OR, 0, 0);
            e.valid = 1'b0;
            e.id    = '0;
            e.err   = 1'b0;
        end
        e.out  = alu(c, m_last);
        m_last = e.out;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e       = exp_q.pop_front();
        obs_rsp = {rsp_valid, rsp_id, rsp_err, rsp_out};
        chk({tag, " rsp"}, 32'(obs_rsp), 32'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int        g;
        alsu_cmd_t c;
        req_valid = '0;
        req_lock  = '0;
        req_cmd   = '0;

        // Reset values
        repeat (2) @(negedge clk);
        req_valid = 2'b11;
        #1;
        chk("reset ready", 32'(req_ready), 32'd0);
        chk("reset alsu_rst", 32'(alsu_rst), 32'd1);
        chk("reset rsp", 32'({rsp_valid, rsp_id, rsp_err, rsp_out}), 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        chk("alsu_rst before edge", 32'(alsu_rst), 32'd1);

        // Single ADD: 3 + 2 + 1
        c = mk(ADD, 3, 2);
        c.cin = 1'b1;
        set_req(0, 1'b1, 1'b0, c);
        cycle("add", g);
        chk("alsu_rst after edge", 32'(alsu_rst), 32'd0);
        set_req(0, 1'b0, 1'b0, '0);
        cycle("add wait", g);
        cycle("add wait", g);
        cycle("add resp", g);
        chk("add result", 32'(obs_rsp), 32'(mkrsp(1'b1, 0, 1'b0, 6)));

        // Locked MULT then SHIFT from requester 1 while requester 0 waits
        set_req(0, 1'b1, 1'b0, mk(ADD, 1, 1));
        set_req(1, 1'b1, 1'b1, mk(MULT, -2, 3));
        cycle("lock A", g);
        chk("lock ready A", 32'(last_ready), 32'(2'b10));
        c = mk(SHIFT, 0, 0);
        c.direction = 1'b1;
        c.serial_in = 1'b1;
        set_req(1, 1'b1, 1'b0, c);
        cycle("lock B", g);
        chk("lock ready B", 32'(last_ready), 32'(2'b10));
        set_req(1, 1'b0, 1'b0, '0);
        cycle("lock C", g);
        set_req(0, 1'b0, 1'b0, '0);
        cycle("lock D", g);
        chk("mult result", 32'(obs_rsp), 32'(mkrsp(1'b1, 1, 1'b0, -6)));
        cycle("lock E", g);
        chk("shift chain result", 32'(obs_rsp), 32'(mkrsp(1'b1, 1, 1'b0, -11)));
        cycle("lock F", g);
        chk("held add result", 32'(obs_rsp), 32'(mkrsp(1'b1, 0, 1'b0, 2)));

        // Both requesters saturated: grants alternate
        set_req(0, 1'b1, 1'b0, mk(ADD, 1, 2));
        set_req(1, 1'b1, 1'b0, mk(ADD, -3, 1));
        for (int i = 0; i < 8; i++) begin
            cycle("alt", g);
            chk("alt ready", 32'(last_ready), (i % 2 == 0) ? 32'(2'b10) : 32'(2'b01));
            if (g >= 0) set_req(g, 1'b1, 1'b0, mk(ADD, int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
        end
        req_valid = '0;
        repeat (LAT + 1) cycle("alt drain", g);

        // OR, idle, SHIFT right: SHIFT sees 0
        set_req(0, 1'b1, 1'b0, mk(OR, 1, 2));
        cycle("or", g);
        set_req(0, 1'b0, 1'b0, '0);
        cycle("or idle", g);
        c = mk(SHIFT, 0, 0);
        c.serial_in = 1'b1;
        set_req(0, 1'b1, 1'b0, c);
        cycle("shift", g);
        set_req(0, 1'b0, 1'b0, '0);
        cycle("or drain", g);
        chk("or result", 32'(obs_rsp), 32'(mkrsp(1'b1, 0, 1'b0, 3)));
        cycle("or drain", g);
        cycle("or drain", g);
        chk("shift after idle", 32'(obs_rsp), 32'(mkrsp(1'b1, 0, 1'b0, -32)));

        // Invalid commands
        set_req(0, 1'b1, 1'b0, mk(INVALID_7, 1, 1));
        cycle("inv7", g);
        c = mk(ADD, 1, 1);
        c.red_op_A = 1'b1;
        set_req(0, 1'b1, 1'b0, c);
        cycle("inv red", g);
        c = mk(INVALID_6, -3, 2);
        c.bypass_A = 1'b1;
        set_req(0, 1'b1, 1'b0, c);
        cycle("inv byp", g);
        set_req(0, 1'b0, 1'b0, '0);
        cycle("inv drain", g);
        chk("opcode7 err", 32'(obs_rsp), 32'(mkrsp(1'b1, 0, 1'b1, 0)));
        cycle("inv drain", g);
        chk("red_op add err", 32'(obs_rsp), 32'(mkrsp(1'b1, 0, 1'b1, 0)));
        cycle("inv drain", g);
        chk("bypass opcode6 err", 32'(obs_rsp), 32'(mkrsp(1'b1, 0, 1'b1, -3)));

        // Random traffic with held-until-accepted requests and random locks
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 0)
                    set_req(i, 1'b1, ($urandom_range(0, 3) == 0), rnd_cmd());
            end
            cycle("rand", g);
            if (g >= 0) req_valid[g] = 1'b0;
        end
        req_valid = '0;
        if (m_owner >= 0) begin
            set_req(m_owner, 1'b1, 1'b0, mk(OR, 0, 0));
            cycle("unlock", g);
            req_valid = '0;
        end
        repeat (LAT + 2) cycle("rand drain", g);

        // Reset mid-stream with the lock held and two commands in flight
        set_req(1, 1'b1, 1'b1, mk(ADD, 1, 2));
        cycle("pre reset", g);
        set_req(1, 1'b1, 1'b1, mk(ADD, 2, 2));
        set_req(0, 1'b1, 1'b0, mk(ADD, 1, 0));
        cycle("pre reset", g);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset ready", 32'(req_ready), 32'd0);
        chk("midreset alsu_rst", 32'(alsu_rst), 32'd1);
        chk("midreset pins idle", 32'({alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in,
                                       alsu_direction, alsu_red_op_A, alsu_red_op_B,
                                       alsu_bypass_A, alsu_bypass_B}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midreset rsp", 32'({rsp_valid, rsp_id, rsp_err, rsp_out}), 32'd0);
        end
        rst_n = 1'b1;
        model_reset();
        #1;
        chk("release alsu_rst before edge", 32'(alsu_rst), 32'd1);
        cycle("post reset", g);
        chk("post reset grant", 32'(last_ready), 32'(2'b01));
        chk("post reset alsu_rst", 32'(alsu_rst), 32'd0);
        req_valid = '0;
        repeat (LAT + 3) cycle("post reset drain", g);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
